dds_lut_writer: RTL

- Write-side counterpart of the DDS lookup-RAM read path.
- Accepts a valid/ready sample stream (from the MCU bridge) and writes it into the half of the dual-port lookup RAM that the wave generator is not reading.
- Half selection follows the generator's ram ISR flag (phase MSB, which equals read-address MSB), giving ping-pong waveform updates with no glitches.
- Sits between the host interface and the RAM write port; same clock domain as the generator unless the sync option is built in.

---
 rtl/dds_lut_writer_pkg.sv | 14 +
 rtl/dds_lut_writer_if.sv | 25 ++
 rtl/dds_lut_writer_isr_edge.sv | 52 +++++
 rtl/dds_lut_writer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dds_lut_writer_pkg.sv
// Shared definitions for the DDS lookup-RAM writer: default widths and
// the writer state encoding.
package dds_pkg;

    localparam int DDS_RAM_ADD_WIDTH = 10;
    localparam int DDS_RAM_DAT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } dds_wr_state_t;

endpackage

// File: rtl/dds_lut_writer_if.sv
// Valid/ready sample stream from the MCU bridge into the LUT writer.
// master = sample source, slave = dds_lut_writer.
interface dds_lut_writer_if
    import dds_pkg::*;
#(
    parameter int DAT_WIDTH = DDS_RAM_DAT_WIDTH
) ();

    logic [DAT_WIDTH-1:0] i_s_data;
    logic                 i_s_valid;
    logic                 o_s_ready;

    modport master (
        output i_s_data,
        output i_s_valid,
        input  o_s_ready
    );

    modport slave (
        input  i_s_data,
        input  i_s_valid,
        output o_s_ready
    );

endinterface

// File: rtl/dds_lut_writer_isr_edge.sv
// Registers the generator ISR flag and flags a half swap (any change of the
// registered flag). With DDS_LUT_WR_SYNC_EN defined, the flag first passes a
// 2-flop synchronizer for a generator on an unrelated clock.
module dds_isr_edge
    import dds_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ram_isr,
    output logic o_isr_q,
    output logic o_swap
);

    logic w_isr_in;
    logic r_isr_q;
    logic r_isr_prev;

`ifdef DDS_LUT_WR_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-stage synchronizer for the asynchronous ISR flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_ram_isr;
            r_sync2 <= r_sync1;
        end
    end

    assign w_isr_in = r_sync2;
`else
    assign w_isr_in = i_ram_isr;
`endif

    // ISR flag register and its one-cycle-old copy for edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_isr_q    <= 1'b0;
            r_isr_prev <= 1'b0;
        end else begin
            r_isr_q    <= w_isr_in;
            r_isr_prev <= r_isr_q;
        end
    end

    assign o_isr_q = r_isr_q;
    assign o_swap  = r_isr_q ^ r_isr_prev;

endmodule

// File: rtl/dds_lut_writer.sv
// DDS lookup-RAM writer: streams HALF samples into the RAM half the wave
// generator is not reading, restarting on every reader half swap.
// Optional build macro: DDS_LUT_WR_SYNC_EN (synchronize i_ram_isr).
module dds_lut_writer
    import dds_pkg::*;
#(
    parameter int _RAM_ADD_WIDTH = DDS_RAM_ADD_WIDTH,
    parameter int _RAM_DAT_WIDTH = DDS_RAM_DAT_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_ram_isr,
    dds_lut_writer_if.slave           s_if,
    output logic                      o_ram_we,
    output logic [_RAM_ADD_WIDTH-1:0] o_ram_address,
    output logic [_RAM_DAT_WIDTH-1:0] o_ram_data,
    output logic                      o_half_req,
    output logic                      o_busy,
    output logic                      o_underrun,
    input  logic                      i_clr_underrun
);

    localparam int CNT_W = _RAM_ADD_WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    dds_wr_state_t r_state, w_state_next;

    logic [CNT_W-1:0]          r_cnt, w_cnt_next;
    logic                      r_tgt, w_tgt_next;
    logic                      r_half_req, w_half_req_next;
    logic                      r_underrun, w_underrun_next;
    logic                      r_we;
    logic [_RAM_ADD_WIDTH-1:0] r_addr;
    logic [_RAM_DAT_WIDTH-1:0] r_data;

    logic w_isr_q;
    logic w_swap;
    logic w_ready;
    logic w_hs;
    logic [_RAM_DAT_WIDTH-1:0] w_s_data;

    dds_isr_edge u_isr_edge (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_ram_isr (i_ram_isr),
        .o_isr_q   (w_isr_q),
        .o_swap    (w_swap)
    );

    assign w_s_data    = s_if.i_s_data;
    assign w_ready     = (r_state == ST_FILL);
    assign w_hs        = s_if.i_s_valid & w_ready;
    assign s_if.o_s_ready = w_ready;

    // State register and fill control registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_tgt      <= 1'b0;
            r_half_req <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_tgt      <= w_tgt_next;
            r_half_req <= w_half_req_next;
            r_underrun <= w_underrun_next;
        end
    end

    // Next-state logic; a swap outranks the final accept so a late fill is
    // restarted rather than reported done
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_tgt_next      = r_tgt;
        w_half_req_next = 1'b0;
        w_underrun_next = r_underrun;

        if (i_clr_underrun) begin
            w_underrun_next = 1'b0;
        end

        if (!i_enable) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next    = ST_FILL;
                    w_tgt_next      = ~w_isr_q;
                    w_cnt_next      = '0;
                    w_half_req_next = 1'b1;
                end
                ST_FILL: begin
                    if (w_swap) begin
                        w_underrun_next = 1'b1;
                        w_tgt_next      = ~w_isr_q;
                        w_cnt_next      = '0;
                        w_half_req_next = 1'b1;
                    end else if (w_hs) begin
                        if (r_cnt == CNT_LAST) begin
                            w_state_next = ST_DONE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_swap) begin
                        w_state_next    = ST_FILL;
                        w_tgt_next      = ~w_isr_q;
                        w_cnt_next      = '0;
                        w_half_req_next = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // RAM write port: one registered write per accepted sample, using the
    // target half and count current at the handshake
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_hs;
            if (w_hs) begin
                r_addr <= {r_tgt, r_cnt};
                r_data <= w_s_data;
            end
        end
    end

    assign o_ram_we      = r_we;
    assign o_ram_address = r_addr;
    assign o_ram_data    = r_data;
    assign o_half_req    = r_half_req;
    assign o_busy        = (r_state == ST_FILL);
    assign o_underrun    = r_underrun;

endmodule
